// File: rtl/miriscv_data_arb.sv
// Two-master arbiter for the miriscv_ram data port: round-robin grant with a
// bounded master-1 burst lock, address range decode and a registered 1-cycle response.
module miriscv_data_arb #(
    parameter int unsigned RAM_SIZE = 256,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    input  logic        m1_lock_i,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam int unsigned      CNT_W      = 8;
    localparam logic [31:0]      RAM_LIMIT  = 32'(RAM_SIZE);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    logic             last_gnt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    logic             gnt0_c;
    logic             gnt1_c;
    logic             lock_active_c;
    logic             in_range_c;
    logic [31:0]      rsp_rdata_c;
    mreq_t            m0_bus_c;
    mreq_t            m1_bus_c;
    mreq_t            sel_bus_c;

    assign m0_bus_c = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_bus_c = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

    // Grant: lock keeps master 1 on the bus until the burst budget runs out.
    always_comb begin
        gnt0_c        = 1'b0;
        gnt1_c        = 1'b0;
        lock_active_c = last_gnt && m1_lock_i && (lock_cnt < LOCK_LIMIT);
        if (m0_req_i && m1_req_i) begin
            if (lock_active_c || !last_gnt) begin
                gnt1_c = 1'b1;
            end else begin
                gnt0_c = 1'b1;
            end
        end else if (m0_req_i) begin
            gnt0_c = 1'b1;
        end else if (m1_req_i) begin
            gnt1_c = 1'b1;
        end
    end

    assign m0_gnt_o = gnt0_c;
    assign m1_gnt_o = gnt1_c;

    // Slave drive: master 0 fields are the idle default.
    always_comb begin
        sel_bus_c   = gnt1_c ? m1_bus_c : m0_bus_c;
        in_range_c  = sel_bus_c.addr < RAM_LIMIT;
        ram_req_o   = (gnt0_c || gnt1_c) && in_range_c;
        ram_we_o    = sel_bus_c.we;
        ram_be_o    = sel_bus_c.be;
        ram_addr_o  = sel_bus_c.addr;
        ram_wdata_o = sel_bus_c.wdata;
        rsp_rdata_c = (ram_req_o && !sel_bus_c.we) ? ram_rdata_i : 32'h0;
    end

    // Lock budget only advances while master 1 actually starves master 0.
    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if (gnt0_c || !m1_lock_i) begin
            lock_cnt_nxt = '0;
        end else if (gnt1_c && m0_req_i && lock_active_c) begin
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt    <= 1'b1;
            lock_cnt    <= '0;
            m0_rvalid_o <= 1'b0;
            m0_rdata_o  <= 32'h0;
            m0_err_o    <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m1_rdata_o  <= 32'h0;
            m1_err_o    <= 1'b0;
        end else begin
            if (gnt0_c || gnt1_c) begin
                last_gnt <= gnt1_c;
            end
            lock_cnt    <= lock_cnt_nxt;
            m0_rvalid_o <= gnt0_c;
            m0_rdata_o  <= gnt0_c ? rsp_rdata_c : 32'h0;
            m0_err_o    <= gnt0_c && !in_range_c;
            m1_rvalid_o <= gnt1_c;
            m1_rdata_o  <= gnt1_c ? rsp_rdata_c : 32'h0;
            m1_err_o    <= gnt1_c && !in_range_c;
        end
    end

endmodule

// File: tb/tb_miriscv_data_arb.sv
// Bench for miriscv_data_arb: behavioural RAM, per-scenario grant checks and a
// response scoreboard that expects each grant's response exactly one cycle later.
module tb_miriscv_data_arb;

    localparam int unsigned RAM_SIZE = 256;
    localparam int unsigned LOCK_MAX = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        ram_req_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic        v0;
        logic        v1;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem [64];

    miriscv_data_arb #(.RAM_SIZE(RAM_SIZE), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o), .m1_lock_i(m1_lock_i),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    // Behavioural RAM: combinational read, byte-enabled write at the clock edge.
    assign ram_rdata_i = mem[ram_addr_o[7:2]];
    always @(posedge clk_i) begin
        if (ram_req_o && ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_o[b]) mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end
        end
    end

    // Scoreboard: every cycle either a due response is compared or silence is required.
    always @(negedge clk_i) begin
        exp_t        e;
        logic [31:0] e0, e1;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e  = sbq.pop_front();
            e0 = e.v0 ? e.rdata : 32'h0;
            e1 = e.v1 ? e.rdata : 32'h0;
            checks++;
            if (m0_rvalid_o !== e.v0 || m1_rvalid_o !== e.v1 || m0_rdata_o !== e0 ||
                m1_rdata_o !== e1 || m0_err_o !== (e.v0 & e.err) || m1_err_o !== (e.v1 & e.err)) begin
                errors++;
                $display("FAIL rsp cyc=%0d got m0 v=%b d=%h e=%b m1 v=%b d=%h e=%b, expected m0 v=%b d=%h e=%b m1 v=%b d=%h e=%b",
                         cyc, m0_rvalid_o, m0_rdata_o, m0_err_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
                         e.v0, e0, e.v0 & e.err, e.v1, e1, e.v1 & e.err);
            end
        end else begin
            checks++;
            if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_rsp cyc=%0d got rvalid m0=%b m1=%b, expected 0 0",
                         cyc, m0_rvalid_o, m1_rvalid_o);
            end
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic we);
        if (we || a >= 32'(RAM_SIZE)) return 32'h0;
        return mem[a[7:2]];
    endfunction

    // Queue the response for a grant made this cycle (m < 0: none may appear).
    task automatic push_exp(input int m, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.due = cyc + 1; e.v0 = (m == 0); e.v1 = (m == 1); e.rdata = rdata; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        m1_lock_i = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        drive_m0(1'b0, 1'b1, 4'h3, 32'h44, 32'h1111_2222);
        drive_m1(1'b0, 1'b0, 4'hC, 32'h88, 32'h3333_4444);
        @(negedge clk_i);
        checks++;
        if ({m0_gnt_o, m1_gnt_o, ram_req_o, m0_err_o, m1_err_o} !== 5'b0 ||
            m0_rdata_o !== 32'h0 || m1_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b%b req=%b err=%b%b d0=%h d1=%h, expected all 0",
                     m0_gnt_o, m1_gnt_o, ram_req_o, m0_err_o, m1_err_o, m0_rdata_o, m1_rdata_o);
        end
        checks++;
        if (ram_addr_o !== 32'h44 || ram_we_o !== 1'b1 || ram_be_o !== 4'h3 || ram_wdata_o !== 32'h1111_2222) begin
            errors++;
            $display("FAIL idle_mux got addr=%h we=%b be=%h wd=%h, expected 00000044 1 3 11112222",
                     ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
        end
        idle(1);
    endtask

    task automatic test_single_read();
        drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk_i);
        checks++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || ram_req_o !== 1'b1 || ram_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL single_read_gnt got gnt=%b%b req=%b addr=%h, expected 10 1 00000010",
                     m0_gnt_o, m1_gnt_o, ram_req_o, ram_addr_o);
        end
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        next_cycle();
        idle(2);
    endtask

    // Solo master-1 grant leaves last_gnt = 1 with the lock counter clear.
    task automatic prime_m1();
        drive_m1(1'b1, 1'b0, 4'hF, 32'h28, 32'h0);
        @(negedge clk_i);
        checks++;
        if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL prime_gnt got gnt=%b%b, expected 01", m0_gnt_o, m1_gnt_o);
        end
        push_exp(1, exp_rdata(32'h28, 1'b0), 1'b0);
        next_cycle();
    endtask

    task automatic test_round_robin();
        prime_m1();
        drive_m0(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        drive_m1(1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 2;
            @(negedge clk_i);
            checks++;
            if (m0_gnt_o !== (g == 0) || m1_gnt_o !== (g == 1)) begin
                errors++;
                $display("FAIL rr_gnt[%0d] got gnt=%b%b, expected m%0d", i, m0_gnt_o, m1_gnt_o, g);
            end
            push_exp(g, exp_rdata(g == 0 ? 32'h20 : 32'h24, 1'b0), 1'b0);
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_lock();
        prime_m1();
        m1_lock_i = 1'b1;
        drive_m0(1'b1, 1'b0, 4'hF, 32'h2C, 32'h0);
        drive_m1(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        // Expect two full bursts of LOCK_MAX, each ended by one m0 grant.
        for (int i = 0; i < 2 * int'(LOCK_MAX) + 3; i++) begin
            int g;
            g = (i == int'(LOCK_MAX) || i == 2 * int'(LOCK_MAX) + 2) ? 0 : 1;
            @(negedge clk_i);
            checks++;
            if (m0_gnt_o !== (g == 0) || m1_gnt_o !== (g == 1)) begin
                errors++;
                $display("FAIL lock_gnt[%0d] got gnt=%b%b, expected m%0d", i, m0_gnt_o, m1_gnt_o, g);
            end
            push_exp(g, exp_rdata(g == 0 ? 32'h2C : 32'h30, 1'b0), 1'b0);
            next_cycle();
        end
        idle(2);
    endtask

    task automatic test_range();
        logic [31:0] addrs [3];
        logic        wes   [3];
        logic [31:0] snap;
        addrs[0] = 32'hFC;  wes[0] = 1'b0;
        addrs[1] = 32'h100; wes[1] = 1'b1;
        addrs[2] = 32'h8000_0010; wes[2] = 1'b0;
        snap = mem[0];
        for (int i = 0; i < 3; i++) begin
            logic inr;
            inr = addrs[i] < 32'(RAM_SIZE);
            drive_m0(1'b1, wes[i], 4'hF, addrs[i], 32'h1234_5678);
            @(negedge clk_i);
            checks++;
            if (m0_gnt_o !== 1'b1 || ram_req_o !== inr) begin
                errors++;
                $display("FAIL range_req[%0d] got gnt=%b req=%b, expected 1 %b", i, m0_gnt_o, ram_req_o, inr);
            end
            push_exp(0, exp_rdata(addrs[i], wes[i]), !inr);
            next_cycle();
        end
        idle(1);
        checks++;
        if (mem[0] !== snap) begin
            errors++;
            $display("FAIL oor_write_discard got mem[0]=%h, expected %h", mem[0], snap);
        end
    endtask

    task automatic test_write_read();
        // mem[12] starts at 5A00_0000 + 12*0001_0203; write bytes 0 and 2 only.
        logic [31:0] merged;
        merged = 32'h5A0C_1824;
        merged[7:0]   = 8'h0F;
        merged[23:16] = 8'hA5;
        drive_m1(1'b1, 1'b1, 4'b0101, 32'h30, 32'hA5A5_0F0F);
        @(negedge clk_i);
        push_exp(1, 32'h0, 1'b0);
        next_cycle();
        drive_m1(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        @(negedge clk_i);
        push_exp(1, merged, 1'b0);
        next_cycle();
        idle(2);
    endtask

    task automatic test_reset_pending();
        drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk_i);
        checks++;
        if (m0_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_gnt got m0_gnt=%b, expected 1", m0_gnt_o);
        end
        push_exp(-1, 32'h0, 1'b0);
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        drive_m1(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        @(negedge clk_i);
        checks++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_gnt got gnt=%b%b, expected 10", m0_gnt_o, m1_gnt_o);
        end
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        next_cycle();
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        push_exp(1, exp_rdata(32'h14, 1'b0), 1'b0);
        next_cycle();
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive_m1(1'b1, 1'b0, 4'hF, 32'(4 * i), 32'h0);
            @(negedge clk_i);
            checks++;
            if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0 || ram_addr_o !== 32'(4 * i)) begin
                errors++;
                $display("FAIL b2b_gnt[%0d] got gnt=%b%b addr=%h, expected 01 %h",
                         i, m0_gnt_o, m1_gnt_o, ram_addr_o, 32'(4 * i));
            end
            push_exp(1, 32'h5A00_0000 + 32'(i) * 32'h0001_0203, 1'b0);
            next_cycle();
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
        mem[4] = 32'hDEAD_BEEF;
        rst_i = 1'b1;
        m1_lock_i = 1'b0;
        drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_range();
        test_write_read();
        test_back_to_back();
        test_reset_pending();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miriscv_data_arb.md
Name: miriscv_data_arb

Overview:
- Two-master arbiter for the single data port of miriscv_ram.
- Master 0 is the miriscv_core data interface. Master 1 is an auxiliary master (program loader or DMA).
- Per cycle it grants at most one master, decodes the address against RAM_SIZE, drives the RAM data port, and returns a registered response one cycle later.
- Round-robin fairness applies, with an optional bounded lock for master 1 bursts.

Parameters:
- RAM_SIZE, 256, RAM size in bytes. Addresses >= RAM_SIZE are out of range.
- LOCK_MAX, 8, maximum consecutive master-1 grants while m1_lock_i is held and master 0 is requesting. Range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  master 0 request
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  4  master 0 byte enables
- m0_addr_i  in  32  master 0 byte address
- m0_wdata_i  in  32  master 0 write data
- m0_gnt_o  out  1  master 0 request accepted this cycle
- m0_rvalid_o  out  1  master 0 response valid
- m0_rdata_o  out  32  master 0 read data
- m0_err_o  out  1  master 0 out-of-range error, qualified by m0_rvalid_o
- m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o: same as master 0, for master 1
- m1_lock_i  in  1  master 1 requests bus retention for a burst
- ram_req_o  out  1  RAM data request
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, combinational for the same-cycle address

Behaviour:
- Reset (rst_i high at a clock edge):
  - All gnt, rvalid and err outputs are 0. rdata outputs are 0.
  - Round-robin pointer last_gnt = 1, so master 0 wins the first contention.
  - Lock counter lock_cnt = 0.
  - Any response pending at reset is dropped; no rvalid is issued for it.
- Grant logic (combinational from req inputs and registered state):
  - Only m0_req_i high: grant master 0.
  - Only m1_req_i high: grant master 1.
  - Both high, lock active (last_gnt == 1, m1_lock_i == 1, lock_cnt < LOCK_MAX): grant master 1.
  - Both high otherwise: grant the master != last_gnt.
  - Exactly one gnt_o is high when any req is high; both gnt_o are 0 when neither req is high.
- Slave drive:
  - ram_we_o, ram_be_o, ram_addr_o and ram_wdata_o are muxed from the granted master. When there is no grant they carry master 0 values.
  - ram_req_o = grant AND (granted addr < RAM_SIZE). Out-of-range accesses never reach the RAM, so writes to them are discarded.
- Response, registered, latency 1:
  - The cycle after a grant, the granted master's rvalid_o = 1 for exactly one cycle.
  - rdata_o = captured ram_rdata_i for an in-range read. rdata_o = 0 for a write or an out-of-range access.
  - err_o = 1 iff the access was out of range.
  - The non-granted master's rvalid_o, rdata_o and err_o are 0.
- Pipelining: a new grant may occur in the same cycle a prior response is presented, giving 1 access per cycle throughput. Masters hold req and request fields stable until gnt.
- State update on each grant:
  - last_gnt <= granted index.
  - lock_cnt: incremented (saturating at LOCK_MAX) when master 1 is granted while m0_req_i is high and the lock path applies.
  - lock_cnt: cleared when master 0 is granted, or when m1_lock_i is low.
- Lock exhaustion: when lock_cnt == LOCK_MAX and master 0 is requesting, master 0 wins the next grant and the counter clears. Worst-case master 0 wait is therefore LOCK_MAX + 1 cycles.
- Address compare is unsigned 32-bit. Addresses with bit 31 set are out of range.

Test Plan:
- Reset, then m0 read addr 0x10 with RAM returning 0xDEADBEEF -> m0_gnt_o=1 in the same cycle; next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m0_err_o=0; m1 outputs all 0.
- Both masters request continuously with m1_lock_i=0 for 6 cycles -> grants M0,M1,M0,M1,M0,M1; each response arrives 1 cycle after its grant.
- m1_lock_i=1 and both requesting, LOCK_MAX=8, m1 granted first -> 8 consecutive m1 grants (cycles 1-8) then an m0 grant (cycle 9); lock_cnt clears.
- m0 write to addr 0x100 (RAM_SIZE=256) -> ram_req_o=0 during the grant; next cycle m0_rvalid_o=1, m0_err_o=1, m0_rdata_o=0; RAM contents unchanged.
- Grant issued, then rst_i=1 on the following edge -> no rvalid is presented; after reset, simultaneous requests grant m0 first.
- Back-to-back m1 reads at 0x0, 0x4, 0x8 with m0 idle -> m1_gnt_o high 3 cycles; m1_rvalid_o high cycles 2-4 carrying the matching RAM data.
